// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter for the core's single synchronous memory port.
// One transaction in flight; reads return after READ_LATENCY cycles with a one-cycle rvalid pulse.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic              req0_we,
  output logic              req0_ready,
  output logic              req0_rvalid,
  output logic [DATA_W-1:0] req0_rdata,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  input  logic              req1_we,
  output logic              req1_ready,
  output logic              req1_rvalid,
  output logic [DATA_W-1:0] req1_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_out,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_data_in,
  output logic              busy,
  output logic              grant_id
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [2:0] LAT = 3'(READ_LATENCY);

  state_t     state_q, state_d;
  logic [2:0] cnt_q;
  logic       last_grant;
  logic       win;
  logic       accept;

  // On a tie the requester that did not win last time goes first.
  always_comb begin
    win = 1'b0;
    if (req0_valid && req1_valid) win = ~last_grant;
    else if (req1_valid)          win = 1'b1;
  end

  assign req0_ready = (state_q == IDLE) && req0_valid && !win;
  assign req1_ready = (state_q == IDLE) && req1_valid &&  win;
  assign accept     = req0_ready || req1_ready;
  assign busy       = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (accept) state_d = ISSUE;
      ISSUE: state_d = mem_we ? IDLE : WAIT;
      WAIT:  if (cnt_q == 3'd1) state_d = RESP;
      RESP:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      mem_address  <= '0;
      mem_data_out <= '0;
      mem_we       <= 1'b0;
      req0_rvalid  <= 1'b0;
      req1_rvalid  <= 1'b0;
      req0_rdata   <= '0;
      req1_rdata   <= '0;
      grant_id     <= 1'b0;
      last_grant   <= 1'b1;
      cnt_q        <= '0;
    end else begin
      req0_rvalid <= 1'b0;
      req1_rvalid <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            mem_address  <= win ? req1_addr  : req0_addr;
            mem_data_out <= win ? req1_wdata : req0_wdata;
            mem_we       <= win ? req1_we    : req0_we;
            grant_id     <= win;
            last_grant   <= win;
          end
        end
        ISSUE: begin
          mem_we <= 1'b0;
          cnt_q  <= LAT;
        end
        WAIT: begin
          cnt_q <= cnt_q - 3'd1;
          // Capture on the last WAIT edge so rvalid and rdata appear together in RESP.
          if (cnt_q == 3'd1) begin
            if (grant_id) begin
              req1_rdata  <= mem_data_in;
              req1_rvalid <= 1'b1;
            end else begin
              req0_rdata  <= mem_data_in;
              req0_rvalid <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
